encoder_round_sequencer: RTL and testbench
==========================================

Name: encoder_round_sequencer

Overview:
- Sequences the matrix-encoder datapath through one full job: load 64 state lines, run NUM_ROUNDS rounds of the five step units, write back 64 lines.
- Step units run in fixed order: column-parity, rotate, permute, revaluate, add-round-constant.
- Replaces the ad-hoc start/done chaining with an explicit FSM that adds a per-stage watchdog, an abort input and a round index for the round-constant unit.

Parameters:
NUM_LINES, 64, lines loaded and written per job
ADDR_W, 6, width of line_addr (log2 NUM_LINES)
NUM_ROUNDS, 24, rounds per job
ROUND_W, 5, width of round_idx
TIMEOUT, 255, max cycles a stage enable may stay high without its done

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  job request, sampled only in IDLE
abort  in  1  synchronous abort, any state
done1..done5  in  1 each  completion from colParity/rotate/permute/revaluate/addRC units
busy  out  1  high in every state except IDLE, DONE and ERROR
inreg_en  out  1  load datapath input register from mem line
wr_en  out  1  write-back strobe
line_addr  out  ADDR_W  line index for load/write
colParity_en, rotate_en, permute_en, revaluate_en, addRC_en  out  1 each  stage enables
round_idx  out  ROUND_W  current round, 0..NUM_ROUNDS-1
done  out  1  one-cycle job-complete pulse
err  out  1  watchdog fired

Behaviour:
- Reset: state=IDLE; every output 0; internal counters 0.
- All outputs are registered (Moore). An output is high in the cycle following the edge that enters its state.
- IDLE: start=1 -> LOAD; clear line_addr, round_idx, err.
- LOAD: inreg_en=1; line_addr increments each cycle 0..NUM_LINES-1; after the cycle with addr NUM_LINES-1 -> CP. line_addr returns to 0.
- CP, ROT, PERM, REV, ARC: the matching *_en is held high for the whole state.
  - If the matching doneN is sampled high while in that state, go to the next stage next edge. The enable drops the same edge.
  - Done inputs of other stages are ignored.
- ARC exit on done5:
  - if round_idx==NUM_ROUNDS-1 -> WRITE;
  - else round_idx+1 -> CP (no bubble cycle).
- WRITE: wr_en=1; line_addr 0..NUM_LINES-1, one per cycle; after the last line -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. round_idx holds its final value until the next start.
- Watchdog:
  - 8-bit counter cleared on entry to each stage state, incremented each cycle in the stage.
  - If it reaches TIMEOUT with no done sampled -> ERROR.
  - ERROR: err=1, all enables 0; stays until start (-> LOAD, err cleared) or rst.
- abort=1: next state IDLE from any state; all outputs 0 next cycle; no done, no err.
- Simultaneous events:
  - abort beats doneN, timeout and start.
  - A doneN arriving on the timeout cycle counts as success.
  - rst beats everything.
- start outside IDLE/ERROR is ignored and not queued.
- Latency with single-cycle stages (doneN high in the first enable cycle): LOAD 64 + stages 5*NUM_ROUNDS + WRITE 64. done is high in cycle 249 after the start-sampling edge (defaults).
- At most one stage enable is high in any cycle. inreg_en, wr_en and the stage enables are mutually exclusive.

Test Plan:
- Nominal job: stub returns doneN=enable the same cycle; pulse start -> inreg_en for 64 cycles with addr 0..63; enables in order CP,ROT,PERM,REV,ARC repeated 24 times with round_idx 0..23; wr_en for 64 cycles with addr 0..63; done exactly at cycle 249; busy low afterward.
- Slow stage: stub delays done3 by 10 cycles in round 5 -> permute_en high 11 cycles; total done cycle 259; order unchanged.
- Watchdog: stub never raises done2 in round 0 -> rotate_en high 255 cycles, then err=1, busy=0, all enables 0. A following start -> err clears and LOAD restarts at addr 0.
- Abort mid-run: assert abort in round 12 while revaluate_en=1, with done4 in the same cycle -> next cycle IDLE, all outputs 0, no done. A new start then runs a full 249-cycle job.
- Reset mid-WRITE at addr 30 -> next cycle all outputs 0, state IDLE; start asserted during the reset cycle is ignored.
- Spurious inputs: start pulsed during LOAD and done1 pulsed during ROT -> no effect; job completes at cycle 249.

Source files
------------

// File: rtl/encoder_round_sequencer_if.sv
// Handshake bundle between the round sequencer and the matrix-encoder datapath.
// The master side is the sequencer; the slave side is the datapath (or a test stub).
interface encoder_round_sequencer_if #(
  parameter int ADDR_W  = 6,
  parameter int ROUND_W = 5
);
  logic               start;
  logic               abort;
  logic               done1;
  logic               done2;
  logic               done3;
  logic               done4;
  logic               done5;
  logic               busy;
  logic               inreg_en;
  logic               wr_en;
  logic [ADDR_W-1:0]  line_addr;
  logic               colParity_en;
  logic               rotate_en;
  logic               permute_en;
  logic               revaluate_en;
  logic               addRC_en;
  logic [ROUND_W-1:0] round_idx;
  logic               done;
  logic               err;

  modport master (
    input  start, abort, done1, done2, done3, done4, done5,
    output busy, inreg_en, wr_en, line_addr,
           colParity_en, rotate_en, permute_en, revaluate_en, addRC_en,
           round_idx, done, err
  );

  modport slave (
    output start, abort, done1, done2, done3, done4, done5,
    input  busy, inreg_en, wr_en, line_addr,
           colParity_en, rotate_en, permute_en, revaluate_en, addRC_en,
           round_idx, done, err
  );
endinterface

// File: rtl/encoder_round_sequencer.sv
// Job sequencer for the matrix encoder: load lines, run the five step units for
// every round with a per-stage watchdog, write lines back. All outputs are registered.
module encoder_round_sequencer #(
  parameter int NUM_LINES  = 64,
  parameter int ADDR_W     = 6,
  parameter int NUM_ROUNDS = 24,
  parameter int ROUND_W    = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  encoder_round_sequencer_if.master bus
);

  localparam int NUM_STAGES = 5;
  localparam int WD_W       = 8;
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_LINES - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CP,
    S_ROT,
    S_PERM,
    S_REV,
    S_ARC,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_W-1:0]       addr_reg, addr_next;
  logic [ROUND_W-1:0]      round_reg, round_next;
  logic [WD_W-1:0]         wd_reg, wd_next;
  logic [NUM_STAGES-1:0]   stage_done;
  logic [NUM_STAGES-1:0]   cur_stage;
  logic [NUM_STAGES-1:0]   stage_sel_next;
  logic [NUM_STAGES-1:0]   en_out;
  logic                    stage_hit;
  logic                    wd_expired;
  logic                    inreg_reg, wr_reg, done_reg, err_reg, busy_reg;

  // One-hot stage select, bit 0 = column-parity ... bit 4 = add-round-constant.
  function automatic logic [NUM_STAGES-1:0] stage_of(state_t s);
    logic [NUM_STAGES-1:0] sel;
    sel = '0;
    case (s)
      S_CP:    sel = 5'b00001;
      S_ROT:   sel = 5'b00010;
      S_PERM:  sel = 5'b00100;
      S_REV:   sel = 5'b01000;
      S_ARC:   sel = 5'b10000;
      default: sel = '0;
    endcase
    return sel;
  endfunction

  assign stage_done = {bus.done5, bus.done4, bus.done3, bus.done2, bus.done1};

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    round_next = round_reg;
    wd_next    = wd_reg + WD_W'(1);
    cur_stage  = stage_of(state_reg);
    // Only the done of the active stage is honoured; a done on the last watchdog cycle still wins.
    stage_hit  = |(cur_stage & stage_done);
    wd_expired = (wd_reg == WD_LAST);

    unique case (state_reg)
      S_IDLE, S_ERROR: begin
        if (bus.start) begin
          state_next = S_LOAD;
          addr_next  = '0;
          round_next = '0;
        end
      end
      S_LOAD: begin
        addr_next = addr_reg + ADDR_W'(1);
        if (addr_reg == LAST_ADDR) begin
          state_next = S_CP;
          addr_next  = '0;
        end
      end
      S_CP: begin
        if (stage_hit)       state_next = S_ROT;
        else if (wd_expired) state_next = S_ERROR;
      end
      S_ROT: begin
        if (stage_hit)       state_next = S_PERM;
        else if (wd_expired) state_next = S_ERROR;
      end
      S_PERM: begin
        if (stage_hit)       state_next = S_REV;
        else if (wd_expired) state_next = S_ERROR;
      end
      S_REV: begin
        if (stage_hit)       state_next = S_ARC;
        else if (wd_expired) state_next = S_ERROR;
      end
      S_ARC: begin
        if (stage_hit) begin
          if (round_reg == LAST_ROUND) begin
            state_next = S_WRITE;
            addr_next  = '0;
          end else begin
            state_next = S_CP;
            round_next = round_reg + ROUND_W'(1);
          end
        end else if (wd_expired) begin
          state_next = S_ERROR;
        end
      end
      S_WRITE: begin
        addr_next = addr_reg + ADDR_W'(1);
        if (addr_reg == LAST_ADDR) begin
          state_next = S_DONE;
          addr_next  = '0;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        addr_next  = '0;
        round_next = '0;
      end
    endcase

    // Watchdog restarts on every state change, including ARC -> CP between rounds.
    if (state_next != state_reg) begin
      wd_next = '0;
    end

    if (bus.abort) begin
      state_next = S_IDLE;
      addr_next  = '0;
      round_next = '0;
      wd_next    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      round_reg <= '0;
      wd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      round_reg <= round_next;
      wd_reg    <= wd_next;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      inreg_reg <= 1'b0;
      wr_reg    <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      inreg_reg <= (state_next == S_LOAD);
      wr_reg    <= (state_next == S_WRITE);
      done_reg  <= (state_next == S_DONE);
      err_reg   <= (state_next == S_ERROR);
      busy_reg  <= !((state_next == S_IDLE) || (state_next == S_DONE) ||
                     (state_next == S_ERROR));
    end
  end

  assign stage_sel_next = stage_of(state_next);

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_en
      logic en_q;
      always_ff @(posedge clk) begin
        if (rst) en_q <= 1'b0;
        else     en_q <= stage_sel_next[gi];
      end
      assign en_out[gi] = en_q;
    end
  endgenerate

  assign bus.colParity_en = en_out[0];
  assign bus.rotate_en    = en_out[1];
  assign bus.permute_en   = en_out[2];
  assign bus.revaluate_en = en_out[3];
  assign bus.addRC_en     = en_out[4];
  assign bus.inreg_en     = inreg_reg;
  assign bus.wr_en        = wr_reg;
  assign bus.line_addr    = addr_reg;
  assign bus.round_idx    = round_reg;
  assign bus.done         = done_reg;
  assign bus.err          = err_reg;
  assign bus.busy         = busy_reg;

endmodule

// File: tb/tb_encoder_round_sequencer.sv
// Bench for encoder_round_sequencer: a delay-programmable stub answers the stage
// enables and a cycle-list model of the job is compared against the outputs every cycle.
module tb_encoder_round_sequencer;

  localparam int NL = 64;
  localparam int NR = 24;
  localparam int TO = 255;

  typedef struct packed {
    logic       inreg;
    logic       wr;
    logic [5:0] addr;
    logic [4:0] en;
    logic [4:0] rnd;
    logic       dn;
    logic       busy;
    logic       err;
  } out_t;

  typedef struct {
    string name;
    int    slow_round;
    int    slow_stage;
    int    slow_delay;
    bit    exp_err;
    int    exp_cycle;
  } job_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encoder_round_sequencer_if bus ();
  encoder_round_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  // Stub: unit k answers after delay_tab[round][k] extra enable cycles.
  int         delay_tab [NR][5];
  int         en_cnt [5];
  logic [4:0] spur_done;
  logic [4:0] en_vec;
  logic [4:0] done_vec;

  assign en_vec = {bus.addRC_en, bus.revaluate_en, bus.permute_en, bus.rotate_en, bus.colParity_en};

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) en_cnt[k] <= en_vec[k] ? en_cnt[k] + 1 : 0;
  end

  always_comb begin
    done_vec = spur_done;
    for (int k = 0; k < 5; k++) begin
      if (en_vec[k] && int'(bus.round_idx) < NR &&
          en_cnt[k] >= delay_tab[int'(bus.round_idx)][k])
        done_vec[k] = 1'b1;
    end
  end

  assign bus.done1 = done_vec[0];
  assign bus.done2 = done_vec[1];
  assign bus.done3 = done_vec[2];
  assign bus.done4 = done_vec[3];
  assign bus.done5 = done_vec[4];

  int   n_pass  = 0;
  int   n_total = 0;
  out_t exp_q[$];
  int   done_cyc;
  int   err_cyc;
  job_vec_t vecs [6];

  function automatic out_t rec(bit inreg, bit wr, int addr, logic [4:0] en, int rnd,
                               bit dn, bit busy, bit err);
    out_t o;
    o.inreg = inreg;
    o.wr    = wr;
    o.addr  = 6'(addr);
    o.en    = en;
    o.rnd   = 5'(rnd);
    o.dn    = dn;
    o.busy  = busy;
    o.err   = err;
    return o;
  endfunction

  function automatic out_t sample();
    return rec(bus.inreg_en, bus.wr_en, int'(bus.line_addr),
               {bus.addRC_en, bus.revaluate_en, bus.permute_en, bus.rotate_en, bus.colParity_en},
               int'(bus.round_idx), bus.done, bus.busy, bus.err);
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("inreg=%0b wr=%0b addr=%0d en=%b rnd=%0d done=%0b busy=%0b err=%0b",
                     o.inreg, o.wr, o.addr, o.en, o.rnd, o.dn, o.busy, o.err);
  endfunction

  task automatic check(string name, out_t exp);
    out_t act;
    act = sample();
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
  endtask

  task automatic check_int(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_delays();
    for (int r = 0; r < NR; r++)
      for (int s = 0; s < 5; s++) delay_tab[r][s] = 0;
  endtask

  // Reference: the job as a flat list of per-cycle outputs, cycle 1 first.
  task automatic build_expected();
    exp_q.delete();
    for (int a = 0; a < NL; a++) exp_q.push_back(rec(1, 0, a, 5'b0, 0, 0, 1, 0));
    for (int r = 0; r < NR; r++) begin
      for (int s = 0; s < 5; s++) begin
        logic [4:0] oh;
        int         n;
        oh = 5'b00001 << s;
        n  = delay_tab[r][s] + 1;
        if (n > TO) begin
          for (int c = 0; c < TO; c++) exp_q.push_back(rec(0, 0, 0, oh, r, 0, 1, 0));
          exp_q.push_back(rec(0, 0, 0, 5'b0, r, 0, 0, 1));
          exp_q.push_back(rec(0, 0, 0, 5'b0, r, 0, 0, 1));
          return;
        end
        for (int c = 0; c < n; c++) exp_q.push_back(rec(0, 0, 0, oh, r, 0, 1, 0));
      end
    end
    for (int a = 0; a < NL; a++) exp_q.push_back(rec(0, 1, a, 5'b0, NR - 1, 0, 1, 0));
    exp_q.push_back(rec(0, 0, 0, 5'b0, NR - 1, 1, 0, 0));
    exp_q.push_back(rec(0, 0, 0, 5'b0, NR - 1, 0, 0, 0));
  endtask

  // stop_kind: 1 = abort, 2 = reset (with start) after comparing cycle stop_at.
  task automatic run_job(string name, int stop_at, int stop_kind, int spur_start_at, int spur_d1_at);
    done_cyc = 0;
    err_cyc  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      spur_done = 5'b0;
      check($sformatf("%s c%0d", name, i + 1), exp_q[i]);
      if (bus.done && done_cyc == 0) done_cyc = i + 1;
      if (bus.err && err_cyc == 0) err_cyc = i + 1;
      if (i + 1 == spur_start_at) bus.start = 1'b1;
      if (i + 1 == spur_d1_at) spur_done = 5'b00001;
      if (i + 1 == stop_at) begin
        if (stop_kind == 1) bus.abort = 1'b1;
        else begin
          rst = 1'b1;
          bus.start = 1'b1;
        end
        break;
      end
    end
  endtask

  initial begin
    out_t zero;
    int   stop;
    zero = rec(0, 0, 0, 5'b0, 0, 0, 0, 0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    spur_done = 5'b0;
    clear_delays();

    vecs[0] = '{"nominal",           -1, 0,    0, 1'b0, 249};
    vecs[1] = '{"slow_permute_r5",    5, 2,   10, 1'b0, 259};
    vecs[2] = '{"watchdog_rot_r0",    0, 1, 1000, 1'b1, 321};
    vecs[3] = '{"restart_after_err", -1, 0,    0, 1'b0, 249};
    vecs[4] = '{"done_on_timeout",   23, 4,  254, 1'b0, 503};
    vecs[5] = '{"slow_cp_r0",         0, 0,    3, 1'b0, 252};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", zero);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", zero);

    foreach (vecs[v]) begin
      clear_delays();
      if (vecs[v].slow_round >= 0)
        delay_tab[vecs[v].slow_round][vecs[v].slow_stage] = vecs[v].slow_delay;
      build_expected();
      run_job(vecs[v].name, 0, 0, 0, 0);
      if (vecs[v].exp_err) begin
        check_int({vecs[v].name, " err_cycle"}, err_cyc, vecs[v].exp_cycle);
        check_int({vecs[v].name, " no_done"}, done_cyc, 0);
      end else begin
        check_int({vecs[v].name, " done_cycle"}, done_cyc, vecs[v].exp_cycle);
        check_int({vecs[v].name, " no_err"}, err_cyc, 0);
      end
    end

    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < NR; r++)
        for (int s = 0; s < 5; s++)
          delay_tab[r][s] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0;
      if (j == 2) delay_tab[$urandom_range(0, NR - 1)][$urandom_range(0, 4)] = 300;
      build_expected();
      run_job($sformatf("random%0d", j), 0, 0, 0, 0);
    end

    // Abort in round 12 while revaluate is enabled and done4 is answering.
    clear_delays();
    build_expected();
    stop = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (stop == 0 && exp_q[i].rnd == 5'd12 && exp_q[i].en == 5'b01000) stop = i + 1;
    end
    run_job("abort_r12", stop, 1, 0, 0);
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_next_cycle", zero);
    repeat (2) begin
      @(negedge clk);
      check("abort_idle", zero);
    end
    check_int("abort no_done", done_cyc, 0);
    build_expected();
    run_job("after_abort", 0, 0, 0, 0);
    check_int("after_abort done_cycle", done_cyc, 249);

    // Reset during write-back at line 30, with start high across the reset edge.
    build_expected();
    run_job("rst_write", 215, 2, 0, 0);
    @(negedge clk);
    check("rst_mid_write", zero);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_start_ignored", zero);
    end

    // Stray start during LOAD and stray done1 during ROT of round 0.
    build_expected();
    run_job("spurious", 0, 0, 10, 66);
    check_int("spurious done_cycle", done_cyc, 249);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
